// File: rtl/cbfp_pkg.sv
// cbfp_pkg
// Shared definitions for the CBFP exponent path (cbfp_shift_calc and the
// downstream bit_shift stage): default widths, the complex sample type and
// the drain FSM state encoding.
package cbfp_pkg;

  localparam int CBFP_DATA_WIDTH  = 25;  // signed width of re/im samples
  localparam int CBFP_SHIFT_WIDTH = 5;   // holds 0..CBFP_DATA_WIDTH-1
  localparam int CBFP_BLOCK_LEN   = 16;  // samples per CBFP block

  typedef struct packed {
    logic signed [CBFP_DATA_WIDTH-1:0] re;
    logic signed [CBFP_DATA_WIDTH-1:0] im;
  } cbfp_sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/cbfp_rsb_count.sv
// cbfp_rsb_count
// Combinational redundant-sign-bit counter: number of bits directly below
// the MSB that equal the MSB (0..DATA_WIDTH-1).
// Ports:
//   x     in  DATA_WIDTH   signed sample
//   count out SHIFT_WIDTH  redundant sign bits of x
module cbfp_rsb_count
  import cbfp_pkg::*;
#(
  parameter int DATA_WIDTH  = CBFP_DATA_WIDTH,
  parameter int SHIFT_WIDTH = CBFP_SHIFT_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0]  x,
  output logic        [SHIFT_WIDTH-1:0] count
);

  logic run;

  // Walk down from just below the MSB; stop counting at the first bit that
  // differs from the sign.
  always_comb begin
    count = '0;
    run   = 1'b1;
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[DATA_WIDTH-1])) begin
        count = count + SHIFT_WIDTH'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cbfp_shift_calc.sv
// cbfp_shift_calc
// Block-floating-point exponent stage. Buffers BLOCK_LEN complex samples in
// one of two ping-pong banks while tracking the minimum redundant-sign-bit
// count of the block, then replays the block unmodified with that minimum
// as a constant shift_value.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_re/in_im  input sample stream, gaps allowed, never stalled
//   out_valid             qualifies out_re/out_im/shift_value
//   out_first             marks sample 0 of each output block
//   out_re/out_im         buffered samples, unmodified
//   shift_value           block minimum, changes only with out_first
module cbfp_shift_calc
  import cbfp_pkg::*;
#(
  parameter int DATA_WIDTH  = CBFP_DATA_WIDTH,
  parameter int SHIFT_WIDTH = CBFP_SHIFT_WIDTH,
  parameter int BLOCK_LEN   = CBFP_BLOCK_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  in_re,
  input  logic signed [DATA_WIDTH-1:0]  in_im,
  output logic                          out_valid,
  output logic                          out_first,
  output logic signed [DATA_WIDTH-1:0]  out_re,
  output logic signed [DATA_WIDTH-1:0]  out_im,
  output logic        [SHIFT_WIDTH-1:0] shift_value
);

  localparam int                     IDX_W    = $clog2(BLOCK_LEN);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BLOCK_LEN - 1);
  localparam logic [SHIFT_WIDTH-1:0] MAX_RSB  = SHIFT_WIDTH'(DATA_WIDTH - 1);

  // ---------------- fill side ----------------
  logic [IDX_W-1:0]       wr_idx_reg;
  logic                   fill_bank_reg;
  logic [SHIFT_WIDTH-1:0] run_min_reg;
  logic [SHIFT_WIDTH-1:0] bank_shift_reg [2];
  logic                   handover_reg;
  logic                   handover_bank_reg;

  logic [SHIFT_WIDTH-1:0] rsb_re, rsb_im, cnt, blk_min;

  cbfp_rsb_count #(.DATA_WIDTH(DATA_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)) u_rsb_re (
    .x     (in_re),
    .count (rsb_re)
  );

  cbfp_rsb_count #(.DATA_WIDTH(DATA_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)) u_rsb_im (
    .x     (in_im),
    .count (rsb_im)
  );

  assign cnt     = (rsb_re < rsb_im) ? rsb_re : rsb_im;
  assign blk_min = (cnt < run_min_reg) ? cnt : run_min_reg;

  // Both banks share one array; the bank select is the address MSB.
  logic [2*DATA_WIDTH-1:0] mem [2*BLOCK_LEN];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[{fill_bank_reg, wr_idx_reg}] <= {in_re, in_im};
    end
  end

  // handover_reg is a one-cycle pulse raised after the last sample of a
  // block has been written, so the drain side reads settled bank contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_reg        <= '0;
      fill_bank_reg     <= 1'b0;
      run_min_reg       <= MAX_RSB;
      bank_shift_reg[0] <= '0;
      bank_shift_reg[1] <= '0;
      handover_reg      <= 1'b0;
      handover_bank_reg <= 1'b0;
    end else begin
      handover_reg <= 1'b0;
      if (in_valid) begin
        if (wr_idx_reg == LAST_IDX) begin
          wr_idx_reg                    <= '0;
          fill_bank_reg                 <= ~fill_bank_reg;
          run_min_reg                   <= MAX_RSB;
          bank_shift_reg[fill_bank_reg] <= blk_min;
          handover_reg                  <= 1'b1;
          handover_bank_reg             <= fill_bank_reg;
        end else begin
          wr_idx_reg  <= wr_idx_reg + IDX_W'(1);
          run_min_reg <= blk_min;
        end
      end
    end
  end

  // ---------------- drain side ----------------
  drain_state_t     state_reg, state_next;
  logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
  logic             rd_bank_reg, rd_bank_next;
  logic             emit;
  logic             emit_bank;
  logic [IDX_W-1:0] emit_idx;
  logic [2*DATA_WIDTH-1:0] rd_word;

  // A handover seen in IDLE emits sample 0 straight away so the first
  // output lands one cycle after the last input is accepted.
  always_comb begin
    state_next   = state_reg;
    rd_idx_next  = rd_idx_reg;
    rd_bank_next = rd_bank_reg;
    emit         = 1'b0;
    emit_bank    = rd_bank_reg;
    emit_idx     = rd_idx_reg;
    case (state_reg)
      IDLE: begin
        if (handover_reg) begin
          emit         = 1'b1;
          emit_bank    = handover_bank_reg;
          emit_idx     = '0;
          state_next   = DRAIN;
          rd_bank_next = handover_bank_reg;
          rd_idx_next  = IDX_W'(1);
        end
      end
      DRAIN: begin
        emit = 1'b1;
        if (rd_idx_reg == LAST_IDX) begin
          rd_idx_next = '0;
          if (handover_reg) begin
            rd_bank_next = handover_bank_reg;
          end else begin
            state_next = IDLE;
          end
        end else begin
          rd_idx_next = rd_idx_reg + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_word = mem[{emit_bank, emit_idx}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rd_idx_reg  <= '0;
      rd_bank_reg <= 1'b0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_re      <= '0;
      out_im      <= '0;
      shift_value <= '0;
    end else begin
      state_reg   <= state_next;
      rd_idx_reg  <= rd_idx_next;
      rd_bank_reg <= rd_bank_next;
      out_valid   <= emit;
      out_first   <= emit && (emit_idx == '0);
      if (emit) begin
        out_re <= $signed(rd_word[2*DATA_WIDTH-1:DATA_WIDTH]);
        out_im <= $signed(rd_word[DATA_WIDTH-1:0]);
      end
      if (emit && (emit_idx == '0)) begin
        shift_value <= bank_shift_reg[emit_bank];
      end
    end
  end

endmodule

// File: tb/tb_cbfp_shift_calc.sv
module tb_cbfp_shift_calc;

  localparam int DW = 25;
  localparam int SW = 5;
  localparam int BL = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 out_valid;
  logic                 out_first;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [SW-1:0]        shift_value;

  cbfp_shift_calc #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .BLOCK_LEN(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_re       (in_re),
    .in_im       (in_im),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_re      (out_re),
    .out_im      (out_im),
    .shift_value (shift_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [SW-1:0]        sh;
    logic                 first;
    int                   cyc;
  } smp_t;

  smp_t cap_q[$];
  smp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_in_cyc = 0;
  logic signed [DW-1:0] blk_re [BL];
  logic signed [DW-1:0] blk_im [BL];

  // Capture every valid output with the cycle it was seen in.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin : cap
      smp_t s;
      s.re = out_re; s.im = out_im; s.sh = shift_value; s.first = out_first; s.cyc = cyc;
      cap_q.push_back(s);
    end
  end

  // Reference: redundant sign bits = DW-1 minus the significant magnitude bits.
  function automatic int rsb_model(input logic signed [DW-1:0] x);
    int v;
    int n;
    v = x;
    if (v < 0) v = -v - 1;
    n = 0;
    while (v > 0) begin
      v = v / 2;
      n++;
    end
    return (DW - 1) - n;
  endfunction

  // Random value with rsb >= m, or exactly m when exact is set.
  function automatic logic signed [DW-1:0] gen_val(input int m, input bit exact);
    int n;
    int v;
    int mask;
    logic signed [DW-1:0] r;
    n = (DW - 1) - m;
    if (n == 0) begin
      v = 0;
    end else if (exact) begin
      mask = (1 << (n - 1)) - 1;
      v = (1 << (n - 1)) | (int'($urandom) & mask);
    end else begin
      mask = (1 << n) - 1;
      v = int'($urandom) & mask;
    end
    if ($urandom_range(1) == 1) v = -v - 1;
    r = v[DW-1:0];
    return r;
  endfunction

  task automatic fill_block_min(input int m);
    int j;
    for (int i = 0; i < BL; i++) begin
      blk_re[i] = gen_val(m, 1'b0);
      blk_im[i] = gen_val(m, 1'b0);
    end
    j = int'($urandom_range(BL - 1));
    if ($urandom_range(1) == 1) blk_re[j] = gen_val(m, 1'b1);
    else                        blk_im[j] = gen_val(m, 1'b1);
  endtask

  // Leaves in_valid high after the last sample so blocks can be chained.
  task automatic drive_block(input int gap_pct);
    for (int i = 0; i < BL; i++) begin
      @(negedge clk);
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_re = DW'($urandom);
        in_im = DW'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_re = blk_re[i];
      in_im = blk_im[i];
      last_in_cyc = cyc;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Expected outputs of the block just driven: unmodified data, block
  // minimum of min(rsb(re), rsb(im)), sample i one+i cycles after acceptance.
  task automatic model_block();
    int m;
    smp_t s;
    m = DW - 1;
    for (int i = 0; i < BL; i++) begin
      if (rsb_model(blk_re[i]) < m) m = rsb_model(blk_re[i]);
      if (rsb_model(blk_im[i]) < m) m = rsb_model(blk_im[i]);
    end
    for (int i = 0; i < BL; i++) begin
      s.re = blk_re[i];
      s.im = blk_im[i];
      s.sh = SW'(m);
      s.first = (i == 0);
      s.cyc = last_in_cyc + 2 + i;
      exp_q.push_back(s);
    end
  endtask

  task automatic clear_queues();
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_out(output bit to);
    int k;
    k = 0;
    while (cap_q.size() < exp_q.size() && k < 400) begin
      @(negedge clk);
      k++;
    end
    to = (cap_q.size() < exp_q.size());
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_first !== 1'b0) begin n_bad++; $display("FAIL reset out_first: got %b want 0", out_first); end
    n_cmp++; if (out_re !== '0) begin n_bad++; $display("FAIL reset out_re: got %0d want 0", out_re); end
    n_cmp++; if (out_im !== '0) begin n_bad++; $display("FAIL reset out_im: got %0d want 0", out_im); end
    n_cmp++; if (shift_value !== '0) begin n_bad++; $display("FAIL reset shift_value: got %0d want 0", shift_value); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (cap_q.size() != 0) begin n_bad++; $display("FAIL reset idle: got %0d outputs want 0", cap_q.size()); end
    $display("test_reset done");
  endtask

  task automatic test_const_block();
    bit to;
    clear_queues();
    for (int i = 0; i < BL; i++) begin blk_re[i] = 4095; blk_im[i] = 1; end
    drive_block(0); model_block(); idle();
    wait_out(to);
    n_cmp++;
    if (to || cap_q.size() != exp_q.size()) begin n_bad++; $display("FAIL const count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if ({cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first} !== {exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first} || cap_q[i].cyc != exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL const sample %0d: got re=%0d im=%0d sh=%0d first=%b cyc=%0d want re=%0d im=%0d sh=%0d first=%b cyc=%0d", i, cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first, cap_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first, exp_q[i].cyc);
      end
    end
    $display("test_const_block: %0d outputs, shift %0d", cap_q.size(), (cap_q.size() > 0) ? cap_q[0].sh : 5'd0);
  endtask

  task automatic test_extremes();
    bit to;
    logic signed [DW-1:0] most_neg;
    clear_queues();
    most_neg = {1'b1, {(DW-1){1'b0}}};
    for (int i = 0; i < BL; i++) begin blk_re[i] = '0; blk_im[i] = '0; end
    blk_re[7] = most_neg;
    drive_block(0); model_block();
    for (int i = 0; i < BL; i++) begin blk_re[i] = -1; blk_im[i] = -1; end
    drive_block(0); model_block(); idle();
    wait_out(to);
    n_cmp++;
    if (to || cap_q.size() != exp_q.size()) begin n_bad++; $display("FAIL extremes count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if ({cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first} !== {exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first} || cap_q[i].cyc != exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL extremes sample %0d: got re=%0d im=%0d sh=%0d first=%b cyc=%0d want re=%0d im=%0d sh=%0d first=%b cyc=%0d", i, cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first, cap_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first, exp_q[i].cyc);
      end
    end
    $display("test_extremes: %0d outputs", cap_q.size());
  endtask

  task automatic test_back_to_back();
    bit to;
    int mins [3];
    mins[0] = 3; mins[1] = 10; mins[2] = 20;
    clear_queues();
    for (int b = 0; b < 3; b++) begin
      fill_block_min(mins[b]);
      drive_block(0);
      model_block();
    end
    idle();
    wait_out(to);
    n_cmp++;
    if (to || cap_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if ({cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first} !== {exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first} || cap_q[i].cyc != exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL b2b sample %0d: got re=%0d im=%0d sh=%0d first=%b cyc=%0d want re=%0d im=%0d sh=%0d first=%b cyc=%0d", i, cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first, cap_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first, exp_q[i].cyc);
      end
    end
    $display("test_back_to_back: %0d outputs", cap_q.size());
  endtask

  task automatic test_gaps();
    bit to;
    clear_queues();
    for (int b = 0; b < 3; b++) begin
      fill_block_min(int'($urandom_range(DW - 1)));
      drive_block(50);
      model_block();
    end
    idle();
    wait_out(to);
    n_cmp++;
    if (to || cap_q.size() != exp_q.size()) begin n_bad++; $display("FAIL gaps count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if ({cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first} !== {exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first} || cap_q[i].cyc != exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL gaps sample %0d: got re=%0d im=%0d sh=%0d first=%b cyc=%0d want re=%0d im=%0d sh=%0d first=%b cyc=%0d", i, cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first, cap_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first, exp_q[i].cyc);
      end
    end
    $display("test_gaps: %0d outputs", cap_q.size());
  endtask

  task automatic test_reset_partial();
    bit to;
    clear_queues();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_re = gen_val(2, 1'b0);
      in_im = gen_val(2, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < BL; i++) begin blk_re[i] = 1; blk_im[i] = 1; end
    drive_block(0); model_block(); idle();
    wait_out(to);
    n_cmp++;
    if (to || cap_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rst_partial count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if ({cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first} !== {exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first} || cap_q[i].cyc != exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL rst_partial sample %0d: got re=%0d im=%0d sh=%0d first=%b cyc=%0d want re=%0d im=%0d sh=%0d first=%b cyc=%0d", i, cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first, cap_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first, exp_q[i].cyc);
      end
    end
    $display("test_reset_partial: %0d outputs", cap_q.size());
  endtask

  task automatic test_reset_drain();
    bit to;
    int k;
    clear_queues();
    fill_block_min(int'($urandom_range(DW - 2, 1)));
    drive_block(0); model_block(); idle();
    k = 0;
    while (cap_q.size() < 6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (cap_q.size() < 6) begin n_bad++; $display("FAIL rst_drain start: got %0d outputs want 6", cap_q.size()); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drain out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_first !== 1'b0) begin n_bad++; $display("FAIL rst_drain out_first: got %b want 0", out_first); end
    n_cmp++; if (out_re !== '0) begin n_bad++; $display("FAIL rst_drain out_re: got %0d want 0", out_re); end
    n_cmp++; if (out_im !== '0) begin n_bad++; $display("FAIL rst_drain out_im: got %0d want 0", out_im); end
    n_cmp++; if (shift_value !== '0) begin n_bad++; $display("FAIL rst_drain shift_value: got %0d want 0", shift_value); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    repeat (40) @(negedge clk);
    n_cmp++;
    if (cap_q.size() != 0) begin n_bad++; $display("FAIL rst_drain quiet: got %0d outputs want 0", cap_q.size()); end
    fill_block_min(int'($urandom_range(DW - 1)));
    drive_block(0); model_block(); idle();
    wait_out(to);
    n_cmp++;
    if (to || cap_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rst_drain count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if ({cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first} !== {exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first} || cap_q[i].cyc != exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL rst_drain sample %0d: got re=%0d im=%0d sh=%0d first=%b cyc=%0d want re=%0d im=%0d sh=%0d first=%b cyc=%0d", i, cap_q[i].re, cap_q[i].im, cap_q[i].sh, cap_q[i].first, cap_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].sh, exp_q[i].first, exp_q[i].cyc);
      end
    end
    $display("test_reset_drain: %0d outputs after reset", cap_q.size());
  endtask

  initial begin
    test_reset();
    test_const_block();
    test_extremes();
    test_back_to_back();
    test_gaps();
    test_reset_partial();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
